uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side control for a 16550-style UART: baud-rate generator, line
// control register, receive FIFO (or single holding register), line status
// register and receive interrupt.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   div_wr, div_din     load baud divisor (restarts the baud counter)
//   lcr_wr, lcr_din     load line control {sticky_parity, eps, pen, wls[1:0]}
//   fifo_en             1 = FIFO_DEPTH-entry FIFO, 0 = single holding register
//   rx_trig             FIFO trigger level select (1/4/8/14 entries)
//   rx_push + flags     receiver completion strobe with data and pe/fe/bi
//   rd_en               pop head entry
//   lsr_rd              line status read, clears sticky error bits
//   baud_pulse          16x oversample tick to the receiver
//   wls/pen/eps/sticky_parity  registered line control to the receiver
//   rd_data             head character (last popped one when empty)
//   lsr                 {FIFO error, 0, 0, BI, FE, PE, OE, DR}
//   count               FIFO occupancy
//   rx_irq              receive interrupt (registered)
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_wr,
   input  logic [DIV_W-1:0] div_din,
   input  logic             lcr_wr,
   input  logic [4:0]       lcr_din,
   input  logic             fifo_en,
   input  logic [1:0]       rx_trig,
   input  logic             rx_push,
   input  logic             rx_pe,
   input  logic             rx_fe,
   input  logic             rx_bi,
   input  logic [7:0]       rx_data,
   input  logic             rd_en,
   input  logic             lsr_rd,
   output logic             baud_pulse,
   output logic [1:0]       wls,
   output logic             pen,
   output logic             eps,
   output logic             sticky_parity,
   output logic [7:0]       rd_data,
   output logic [7:0]       lsr,
   output logic [4:0]       count,
   output logic             rx_irq
);

   localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

   // Baud generator state
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] bcnt_q, bcnt_d;
   logic             bpulse_q, bpulse_d;
   // Line control
   logic [4:0]       lcr_q, lcr_d;
   // FIFO storage: entry = {bi, fe, pe, data}
   logic [10:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   // Number of stored entries carrying any error flag
   logic [4:0]       err_q, err_d;
   // Sticky status {bi, fe, pe, oe}
   logic [3:0]       st_q, st_d;
   logic [3:0]       st_set_s;
   logic [7:0]       last_q, last_d;
   logic             irq_q, irq_d;
   logic             en_q;

   logic             flush_s;
   logic             full_s;
   logic             pop_s;
   logic             push_s;
   logic             ovr_s;
   logic [10:0]      head_s;
   logic [4:0]       lvl_s;

   assign head_s = mem_q[rd_ptr_q];

   // Next-state logic for baud generator, line control, FIFO and status
   always_comb begin
      div_d    = div_q;
      bcnt_d   = bcnt_q;
      bpulse_d = 1'b0;
      lcr_d    = lcr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      last_d   = last_q;
      st_set_s = 4'b0000;

      // Baud counter: reload on load, tick when the count reaches 1
      if (div_wr) begin
         div_d  = div_din;
         bcnt_d = div_din;
      end else if (div_q == DIV_W'(0)) begin
         bcnt_d = DIV_W'(0);
      end else if (bcnt_q <= DIV_W'(1)) begin
         bpulse_d = 1'b1;
         bcnt_d   = div_q;
      end else begin
         bcnt_d = bcnt_q - DIV_W'(1);
      end

      if (lcr_wr) begin
         lcr_d = lcr_din;
      end else begin
         lcr_d = lcr_q;
      end

      // A mode change empties the FIFO; traffic in that cycle is dropped
      flush_s = (fifo_en != en_q);
      full_s  = fifo_en ? (count_q == DEPTH_C) : (count_q != 5'd0);
      pop_s   = rd_en && (count_q != 5'd0) && !flush_s;
      // A full FIFO still accepts a push when a pop frees a slot the same cycle
      push_s  = rx_push && !flush_s && (!full_s || pop_s);
      ovr_s   = rx_push && !flush_s && full_s && !pop_s;

      if (flush_s) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = 5'd0;
         err_d    = 5'd0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = head_s[7:0];
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + {4'b0000, push_s} - {4'b0000, pop_s};
         err_d   = err_q + {4'b0000, push_s && (rx_pe || rx_fe || rx_bi)}
                         - {4'b0000, pop_s && (head_s[10:8] != 3'b000)};
      end

      st_set_s = {rx_bi && push_s, rx_fe && push_s, rx_pe && push_s, ovr_s};
      // Set beats a simultaneous status read
      st_d     = st_set_s | (lsr_rd ? 4'b0000 : st_q);

      case (rx_trig)
         2'b00:   lvl_s = 5'd1;
         2'b01:   lvl_s = 5'd4;
         2'b10:   lvl_s = 5'd8;
         2'b11:   lvl_s = 5'd14;
         default: lvl_s = 5'd1;
      endcase

      irq_d = (fifo_en ? (count_d >= lvl_s) : (count_d != 5'd0)) || (st_d != 4'b0000);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q    <= DIV_W'(0);
         bcnt_q   <= DIV_W'(0);
         bpulse_q <= 1'b0;
         lcr_q    <= 5'b00000;
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= 5'd0;
         err_q    <= 5'd0;
         st_q     <= 4'b0000;
         last_q   <= 8'h00;
         irq_q    <= 1'b0;
         en_q     <= fifo_en;
      end else begin
         div_q    <= div_d;
         bcnt_q   <= bcnt_d;
         bpulse_q <= bpulse_d;
         lcr_q    <= lcr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         st_q     <= st_d;
         last_q   <= last_d;
         irq_q    <= irq_d;
         en_q     <= fifo_en;
      end
   end

   // FIFO storage write; contents need no reset since count gates reads
   always_ff @(posedge clk) begin
      if (rst && push_s) begin
         mem_q[wr_ptr_q] <= {rx_bi, rx_fe, rx_pe, rx_data};
      end
   end

   assign baud_pulse    = bpulse_q;
   assign wls           = lcr_q[1:0];
   assign pen           = lcr_q[2];
   assign eps           = lcr_q[3];
   assign sticky_parity = lcr_q[4];
   assign rd_data       = (count_q != 5'd0) ? head_s[7:0] : last_q;
   assign lsr           = {(err_q != 5'd0), 2'b00, st_q, (count_q != 5'd0)};
   assign count         = count_q;
   assign rx_irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed scenarios with literal expectations, followed by randomized traffic.
// A queue-based reference model is updated on every clock edge and all outputs
// are compared against it one time unit after each edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        rst, div_wr, lcr_wr, fifo_en;
   logic [15:0] div_din;
   logic [4:0]  lcr_din;
   logic [1:0]  rx_trig;
   logic        rx_push, rx_pe, rx_fe, rx_bi, rd_en, lsr_rd;
   logic [7:0]  rx_data;
   logic        baud_pulse, pen, eps, sticky_parity, rx_irq;
   logic [1:0]  wls;
   logic [7:0]  rd_data, lsr;
   logic [4:0]  count;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .div_wr(div_wr), .div_din(div_din),
      .lcr_wr(lcr_wr), .lcr_din(lcr_din), .fifo_en(fifo_en), .rx_trig(rx_trig),
      .rx_push(rx_push), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
      .rx_data(rx_data), .rd_en(rd_en), .lsr_rd(lsr_rd),
      .baud_pulse(baud_pulse), .wls(wls), .pen(pen), .eps(eps),
      .sticky_parity(sticky_parity), .rd_data(rd_data), .lsr(lsr),
      .count(count), .rx_irq(rx_irq)
   );

   int nerr = 0;
   int nchk = 0;

   // Reference model state
   logic [10:0] mq[$];
   logic [3:0]  m_st;        // {bi, fe, pe, oe}
   logic [7:0]  m_last;
   logic [4:0]  m_lcr;
   logic        m_irq;
   logic        m_en_prev;
   int          m_div = 0;
   int          m_load = 0;
   int          cyc_n = 0;
   bit          m_valid = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int trig_lvl(input logic [1:0] t);
      case (t)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 14;
      endcase
   endfunction

   task automatic model_edge();
      int         depth;
      bit         full, pop, acc;
      logic [3:0] set_b;
      cyc_n++;
      if (!rst) begin
         mq.delete();
         m_st = 4'b0000; m_last = 8'h00; m_lcr = 5'b00000; m_irq = 1'b0;
         m_div = 0; m_load = 0; m_en_prev = fifo_en; m_valid = 1;
      end else begin
         if (div_wr) begin
            m_div  = int'(div_din);
            m_load = cyc_n;
         end
         if (lcr_wr) m_lcr = lcr_din;
         set_b = 4'b0000;
         if (fifo_en != m_en_prev) begin
            mq.delete();
         end else begin
            depth = fifo_en ? 16 : 1;
            full  = (mq.size() >= depth);
            pop   = rd_en && (mq.size() > 0);
            acc   = rx_push && (!full || pop);
            if (rx_push && !acc) set_b[0] = 1'b1;
            if (pop) begin
               m_last = mq[0][7:0];
               void'(mq.pop_front());
            end
            if (acc) begin
               mq.push_back({rx_bi, rx_fe, rx_pe, rx_data});
               set_b[3:1] = {rx_bi, rx_fe, rx_pe};
            end
         end
         m_st      = set_b | (lsr_rd ? 4'b0000 : m_st);
         m_en_prev = fifo_en;
         m_irq     = (fifo_en ? (mq.size() >= trig_lvl(rx_trig)) : (mq.size() != 0))
                     || (m_st != 4'b0000);
      end
   endtask

   task automatic compare();
      bit         exp_pulse, errf;
      int         el;
      logic [7:0] exp_rd;
      if (!m_valid) return;
      el        = cyc_n - m_load;
      exp_pulse = (m_div != 0) && (el > 0) && ((el % m_div) == 0);
      errf      = 1'b0;
      foreach (mq[i]) if (mq[i][10:8] != 3'b000) errf = 1'b1;
      exp_rd    = (mq.size() > 0) ? mq[0][7:0] : m_last;
      chk("baud_pulse", 32'(baud_pulse), 32'(exp_pulse));
      chk("lcr_out", 32'({wls, pen, eps, sticky_parity}),
          32'({m_lcr[1:0], m_lcr[2], m_lcr[3], m_lcr[4]}));
      chk("count", 32'(count), 32'(mq.size()));
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
      chk("lsr", 32'(lsr), 32'({errf, 2'b00, m_st, (mq.size() != 0)}));
      chk("rx_irq", 32'(rx_irq), 32'(m_irq));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic idle();
      div_wr = 1'b0; lcr_wr = 1'b0; rx_push = 1'b0; rx_pe = 1'b0;
      rx_fe = 1'b0; rx_bi = 1'b0; rd_en = 1'b0; lsr_rd = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input logic pe);
      rx_push = 1'b1; rx_data = d; rx_pe = pe;
      step();
      rx_push = 1'b0; rx_pe = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      int first, n, pp, rp;
      idle();
      rst = 1'b0; fifo_en = 1'b0; rx_trig = 2'b00;
      div_din = 16'd0; lcr_din = 5'd0; rx_data = 8'h00;
      step(); step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_lsr", 32'(lsr), 32'h00);
      chk("rst_rd_data", 32'(rd_data), 32'h00);
      chk("rst_irq", 32'(rx_irq), 32'd0);
      rst = 1'b1;
      step();

      // Divisor 6: pulses at 6, 12, 18 cycles after the load
      div_wr = 1'b1; div_din = 16'd6;
      step();
      div_wr = 1'b0;
      first = -1; n = 0;
      for (int i = 1; i <= 18; i++) begin
         step();
         if (baud_pulse === 1'b1) begin
            n++;
            if (first < 0) first = i;
         end
      end
      chk("baud_first", 32'(first), 32'd6);
      chk("baud_cnt6", 32'(n), 32'd3);

      div_wr = 1'b1; div_din = 16'd0;
      step();
      div_wr = 1'b0; n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (baud_pulse !== 1'b0) n++;
      end
      chk("baud_div0", 32'(n), 32'd0);

      lcr_wr = 1'b1; lcr_din = 5'h07;
      step();
      lcr_wr = 1'b0;
      chk("lcr_07", 32'({wls, pen, eps, sticky_parity}), 32'(5'b11100));

      // FIFO mode, single character
      fifo_en = 1'b1; rx_trig = 2'b00;
      step();
      push(8'h45, 1'b0);
      chk("one_count", 32'(count), 32'd1);
      chk("one_lsr", 32'(lsr), 32'h01);
      chk("one_rd", 32'(rd_data), 32'h45);
      chk("one_irq", 32'(rx_irq), 32'd1);
      pop();
      chk("pop_count", 32'(count), 32'd0);
      chk("pop_lsr", 32'(lsr), 32'h00);
      chk("pop_irq", 32'(rx_irq), 32'd0);
      chk("empty_rd", 32'(rd_data), 32'h45);

      // Push and pop together while empty
      rx_push = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
      step();
      idle();
      chk("empty_pp_count", 32'(count), 32'd1);
      pop();

      // Overrun: 17 pushes into 16 entries
      for (int i = 0; i <= 16; i++) push(8'(i), 1'b0);
      chk("ovr_count", 32'(count), 32'd16);
      chk("ovr_oe", 32'(lsr[1]), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("ovr_pop_data", 32'(rd_data), 32'(i));
         pop();
      end
      chk("ovr_drained", 32'(count), 32'd0);
      lsr_rd = 1'b1;
      step();
      lsr_rd = 1'b0;
      chk("ovr_oe_clr", 32'(lsr[1]), 32'd0);

      // Error-entry tracking
      push(8'h55, 1'b1);
      push(8'h66, 1'b0);
      chk("err_lsr", 32'(lsr), 32'h85);
      pop();
      chk("err_fifo_bit", 32'(lsr[7]), 32'd0);
      chk("err_pe_sticky", 32'(lsr[2]), 32'd1);
      lsr_rd = 1'b1;
      step();
      lsr_rd = 1'b0;
      chk("err_pe_clr", 32'(lsr[2]), 32'd0);
      pop();

      // Full FIFO with simultaneous push and pop, then reset mid-stream
      for (int i = 0; i < 16; i++) push(8'(8'hA0 + i), 1'b0);
      rx_push = 1'b1; rx_data = 8'hEE; rd_en = 1'b1;
      step();
      chk("full_pp_count", 32'(count), 32'd16);
      chk("full_pp_oe", 32'(lsr[1]), 32'd0);
      chk("full_pp_head", 32'(rd_data), 32'hA1);
      rst = 1'b0;
      step();
      idle();
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_lsr", 32'(lsr), 32'h00);
      chk("mid_rst_rd", 32'(rd_data), 32'h00);
      chk("mid_rst_irq", 32'(rx_irq), 32'd0);
      chk("mid_rst_wls", 32'(wls), 32'd0);
      rst = 1'b1;
      step();

      // Randomized traffic in four push/pop bias phases
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0:       begin pp = 70; rp = 30; end
            1:       begin pp = 30; rp = 70; end
            2:       begin pp = 50; rp = 50; end
            default: begin pp = 90; rp = 60; end
         endcase
         for (int c = 0; c < 1000; c++) begin
            rst     = ($urandom_range(999) >= 3);
            div_wr  = ($urandom_range(99) < 2);
            div_din = 16'($urandom_range(7));
            lcr_wr  = ($urandom_range(99) < 5);
            lcr_din = 5'($urandom);
            if ($urandom_range(99) < 1) fifo_en = ~fifo_en;
            if ($urandom_range(99) < 3) rx_trig = 2'($urandom_range(3));
            rx_push = ($urandom_range(99) < pp);
            rd_en   = ($urandom_range(99) < rp);
            rx_pe   = ($urandom_range(99) < 10);
            rx_fe   = ($urandom_range(99) < 10);
            rx_bi   = ($urandom_range(99) < 5);
            rx_data = 8'($urandom);
            lsr_rd  = ($urandom_range(99) < 8);
            step();
         end
      end
      idle();
      rst = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
